// File: rtl/ecc_rd_err_stage.sv
// Read-side stage behind the SECDED corrector: 2-entry skid buffer toward the consumer
// plus saturating SBE/DBE counters, a first-error capture register and a sticky irq.
module ecc_rd_err_stage #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sbit_err,
    output logic                  out_dbit_err,
    input  logic                  irq_sbe_en,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  sbe_cnt,
    output logic [CNT_WIDTH-1:0]  dbe_cnt,
    output logic                  err_cap_vld,
    output logic [ADDR_WIDTH-1:0] err_cap_addr,
    output logic                  err_cap_dbe,
    output logic                  irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Handshake: a word moves on a side only in a cycle where that side's vld and rdy are both high;
    // vld never waits on rdy, and in_rdy is a flop so it never depends combinationally on out_rdy.
    logic                  main_vld_q, main_vld_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                  main_sbe_q, main_sbe_d;
    logic                  main_dbe_q, main_dbe_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_sbe_q, skid_sbe_d;
    logic                  skid_dbe_q, skid_dbe_d;
    logic                  rdy_q, rdy_d;
    logic [CNT_WIDTH-1:0]  sbe_cnt_q, sbe_cnt_d;
    logic [CNT_WIDTH-1:0]  dbe_cnt_q, dbe_cnt_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic                  cap_dbe_q, cap_dbe_d;
    logic                  irq_q, irq_d;

    logic                  acc, drain, in_sbe, in_dbe;
    logic [CNT_WIDTH-1:0]  sbe_base, dbe_base;
    logic                  cap_vld_b, cap_dbe_b, irq_b;
    logic [ADDR_WIDTH-1:0] cap_addr_b;

    always_comb begin
        acc    = in_vld & rdy_q;
        drain  = main_vld_q & out_rdy;
        in_dbe = in_dbit_err;
        in_sbe = in_sbit_err & ~in_dbit_err;

        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_sbe_d  = main_sbe_q;
        main_dbe_d  = main_dbe_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_sbe_d  = skid_sbe_q;
        skid_dbe_d  = skid_dbe_q;

        // rdy_q == !skid_vld_q, so an accept never coincides with a full skid entry.
        if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                main_sbe_d  = skid_sbe_q;
                main_dbe_d  = skid_dbe_q;
                skid_vld_d  = 1'b0;
            end else begin
                main_vld_d = acc;
                if (acc) begin
                    main_data_d = in_data;
                    main_sbe_d  = in_sbe;
                    main_dbe_d  = in_dbe;
                end
            end
        end else if (acc) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
            skid_sbe_d  = in_sbe;
            skid_dbe_d  = in_dbe;
        end
        rdy_d = ~skid_vld_d;

        // clr wipes the old state first; the word accepted in the same cycle then lands on top.
        sbe_base   = clr ? '0 : sbe_cnt_q;
        dbe_base   = clr ? '0 : dbe_cnt_q;
        cap_vld_b  = clr ? 1'b0 : cap_vld_q;
        cap_dbe_b  = clr ? 1'b0 : cap_dbe_q;
        cap_addr_b = clr ? '0 : cap_addr_q;
        irq_b      = clr ? 1'b0 : irq_q;

        sbe_cnt_d  = sbe_base;
        dbe_cnt_d  = dbe_base;
        cap_vld_d  = cap_vld_b;
        cap_dbe_d  = cap_dbe_b;
        cap_addr_d = cap_addr_b;
        irq_d      = irq_b;

        if (acc && in_sbe && sbe_base != CNT_MAX) sbe_cnt_d = sbe_base + 1'b1;
        if (acc && in_dbe && dbe_base != CNT_MAX) dbe_cnt_d = dbe_base + 1'b1;

        if (acc && in_dbe && !(cap_vld_b && cap_dbe_b)) begin
            cap_vld_d  = 1'b1;
            cap_dbe_d  = 1'b1;
            cap_addr_d = in_addr;
            irq_d      = 1'b1;
        end else if (acc && in_sbe && !cap_vld_b) begin
            cap_vld_d  = 1'b1;
            cap_dbe_d  = 1'b0;
            cap_addr_d = in_addr;
            if (irq_sbe_en) irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_sbe_q  <= 1'b0;
            main_dbe_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sbe_q  <= 1'b0;
            skid_dbe_q  <= 1'b0;
            rdy_q       <= 1'b0;
            sbe_cnt_q   <= '0;
            dbe_cnt_q   <= '0;
            cap_vld_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_dbe_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_sbe_q  <= main_sbe_d;
            main_dbe_q  <= main_dbe_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_sbe_q  <= skid_sbe_d;
            skid_dbe_q  <= skid_dbe_d;
            rdy_q       <= rdy_d;
            sbe_cnt_q   <= sbe_cnt_d;
            dbe_cnt_q   <= dbe_cnt_d;
            cap_vld_q   <= cap_vld_d;
            cap_addr_q  <= cap_addr_d;
            cap_dbe_q   <= cap_dbe_d;
            irq_q       <= irq_d;
        end
    end

    assign in_rdy       = rdy_q;
    assign out_vld      = main_vld_q;
    assign out_data     = main_data_q;
    assign out_sbit_err = main_sbe_q;
    assign out_dbit_err = main_dbe_q;
    assign sbe_cnt      = sbe_cnt_q;
    assign dbe_cnt      = dbe_cnt_q;
    assign err_cap_vld  = cap_vld_q;
    assign err_cap_addr = cap_addr_q;
    assign err_cap_dbe  = cap_dbe_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_ecc_rd_err_stage.sv
// Scoreboard bench for ecc_rd_err_stage: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of buffering and error bookkeeping.
module tb_ecc_rd_err_stage;

    localparam int DW = 60;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_addr = '0;
    logic          in_sbit_err = 1'b0;
    logic          in_dbit_err = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sbit_err;
    logic          out_dbit_err;
    logic          irq_sbe_en = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] sbe_cnt;
    logic [CW-1:0] dbe_cnt;
    logic          err_cap_vld;
    logic [AW-1:0] err_cap_addr;
    logic          err_cap_dbe;
    logic          irq;

    ecc_rd_err_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_addr(in_addr),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
        .irq_sbe_en(irq_sbe_en), .clr(clr),
        .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
        .err_cap_vld(err_cap_vld), .err_cap_addr(err_cap_addr), .err_cap_dbe(err_cap_dbe),
        .irq(irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: {dbe tag, sbe tag, data} of every accepted, not yet delivered word
    logic [DW+1:0] exp_q[$];

    // reference model of the software-visible error state
    int          m_sbe = 0;
    int          m_dbe = 0;
    logic        m_cap_vld = 1'b0;
    logic [AW-1:0] m_cap_addr = '0;
    logic        m_cap_dbe = 1'b0;
    logic        m_irq = 1'b0;

    logic          rst_prev = 1'b1;
    logic          hold_prev = 1'b0;
    logic [DW+1:0] held_word = '0;

    // monitor: everything sampled on the falling edge, mid-cycle
    always @(negedge clk) begin
        logic [DW+1:0] cur;
        logic [DW+1:0] exp_w;
        cur = {out_dbit_err, out_sbit_err, out_data};

        if (rst_prev) begin
            chk("rst_in_rdy", 64'(in_rdy), 64'd0);
            chk("rst_out_vld", 64'(out_vld), 64'd0);
            chk("rst_out_word", 64'(cur), 64'd0);
        end else begin
            chk("in_rdy", 64'(in_rdy), 64'(exp_q.size() < 2));
            chk("out_vld", 64'(out_vld), 64'(exp_q.size() > 0));
            if (hold_prev) chk("hold_stable", 64'({out_vld, cur}), 64'({1'b1, held_word}));
        end
        chk("sbe_cnt", 64'(sbe_cnt), 64'(m_sbe));
        chk("dbe_cnt", 64'(dbe_cnt), 64'(m_dbe));
        chk("err_cap", 64'({err_cap_vld, err_cap_dbe, err_cap_addr}),
            64'({m_cap_vld, m_cap_dbe, m_cap_addr}));
        chk("irq", 64'(irq), 64'(m_irq));

        if (rst) begin
            exp_q.delete();
            m_sbe = 0; m_dbe = 0;
            m_cap_vld = 1'b0; m_cap_addr = '0; m_cap_dbe = 1'b0; m_irq = 1'b0;
        end else begin
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(cur), 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("out_word", 64'(cur), 64'(exp_w));
                end
            end
            if (clr) begin
                m_sbe = 0; m_dbe = 0;
                m_cap_vld = 1'b0; m_cap_addr = '0; m_cap_dbe = 1'b0; m_irq = 1'b0;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back({in_dbit_err, in_sbit_err & ~in_dbit_err, in_data});
                if (in_dbit_err) begin
                    m_dbe = (m_dbe < CMAX) ? m_dbe + 1 : CMAX;
                    if (!(m_cap_vld && m_cap_dbe)) begin
                        m_cap_vld = 1'b1; m_cap_dbe = 1'b1; m_cap_addr = in_addr; m_irq = 1'b1;
                    end
                end else if (in_sbit_err) begin
                    m_sbe = (m_sbe < CMAX) ? m_sbe + 1 : CMAX;
                    if (!m_cap_vld) begin
                        m_cap_vld = 1'b1; m_cap_dbe = 1'b0; m_cap_addr = in_addr;
                        if (irq_sbe_en) m_irq = 1'b1;
                    end
                end
            end
        end
        hold_prev = out_vld && !out_rdy && !rst;
        held_word = cur;
        rst_prev  = rst;
    end

    // driver: present one word and hold it until accepted (bounded)
    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a,
                        input logic s, input logic db);
        bit ok;
        in_vld = 1'b1; in_data = d; in_addr = a; in_sbit_err = s; in_dbit_err = db;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_rdy = 1'b1;

        // back-to-back clean words
        for (int i = 1; i <= 4; i++) send(DW'(i), 8'(i), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // downstream stall of 3 cycles during a stream
        fork
            for (int i = 0; i < 6; i++) send(DW'(64'h100 + i), 8'(i), 1'b0, 1'b0);
            begin
                out_rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_rdy = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // SBE, DBE, SBE with SBE irq disabled
        irq_sbe_en = 1'b0;
        pulse_clr();
        send(DW'(64'hA1), 8'h12, 1'b1, 1'b0);
        send(DW'(64'hA2), 8'h34, 1'b0, 1'b1);
        send(DW'(64'hA3), 8'h56, 1'b1, 1'b0);
        chk("seq_sbe_cnt", 64'(sbe_cnt), 64'd2);
        chk("seq_dbe_cnt", 64'(dbe_cnt), 64'd1);
        chk("seq_cap_addr", 64'(err_cap_addr), 64'h34);
        chk("seq_cap_dbe", 64'(err_cap_dbe), 64'd1);
        chk("seq_irq", 64'(irq), 64'd1);

        // both flags on one word count as DBE only
        send(DW'(64'hB0), 8'h78, 1'b1, 1'b1);
        chk("both_sbe_cnt", 64'(sbe_cnt), 64'd2);
        chk("both_dbe_cnt", 64'(dbe_cnt), 64'd2);
        repeat (3) @(posedge clk);
        #1;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            in_vld      = 1'($urandom_range(0, 1));
            in_data     = {28'($urandom), $urandom};
            in_addr     = 8'($urandom);
            in_sbit_err = ($urandom_range(0, 3) == 0);
            in_dbit_err = ($urandom_range(0, 7) == 0);
            clr         = ($urandom_range(0, 63) == 0);
            irq_sbe_en  = 1'($urandom_range(0, 1));
            out_rdy     = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0; clr = 1'b0;
        out_rdy = 1'b1; irq_sbe_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // counter saturation, then clr coincident with an SBE
        pulse_clr();
        for (int i = 0; i < CMAX + 2; i++) send(DW'(i), 8'h10, 1'b1, 1'b0);
        chk("sat_sbe_cnt", 64'(sbe_cnt), 64'hFFFF);
        irq_sbe_en = 1'b1;
        clr = 1'b1;
        send(DW'(64'hC0), 8'h77, 1'b1, 1'b0);
        clr = 1'b0;
        chk("clr_sbe_cnt", 64'(sbe_cnt), 64'd1);
        chk("clr_cap", 64'({err_cap_vld, err_cap_dbe, err_cap_addr}), 64'({1'b1, 1'b0, 8'h77}));
        chk("clr_irq", 64'(irq), 64'd1);
        irq_sbe_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset with both entries full and downstream stalled
        out_rdy = 1'b0;
        send(DW'(64'hD1), 8'h21, 1'b0, 1'b1);
        send(DW'(64'hD2), 8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstmid_out_vld", 64'(out_vld), 64'd0);
        chk("rstmid_dbe_cnt", 64'(dbe_cnt), 64'd0);
        chk("rstmid_irq", 64'(irq), 64'd0);
        out_rdy = 1'b1;
        send(DW'(64'hE5), 8'h30, 1'b0, 1'b0);
        chk("post_rst_latency", 64'({out_vld, out_data}), 64'({1'b1, 60'hE5}));

        // drain
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
